// File: rtl/multi_timer.sv
// Multi-channel down-counting timer with per-channel prescaler, one-shot or
// auto-reload modes, sticky pending flags and a masked interrupt OR.
module multi_timer #(
    parameter int unsigned N_CH  = 2,
    parameter int unsigned CNT_W = 32
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic [5:2]  ADD_I,
    input  logic        WE_I,
    input  logic [31:0] DAT_I,
    output logic [31:0] DAT_O,
    output logic        IRQ
);
    localparam int unsigned PS_W = 15;
    localparam logic [1:0] SEL_CTRL   = 2'b00;
    localparam logic [1:0] SEL_PRESET = 2'b01;
    localparam logic [1:0] SEL_COUNT  = 2'b10;
    localparam logic [1:0] SEL_STATUS = 2'b11;

    logic [31:0]     rd_vec [N_CH];
    logic [N_CH-1:0] irq_vec;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [7:0]       ctrl;
        logic [CNT_W-1:0] preset;
        logic [CNT_W-1:0] count;
        logic             pend;
        logic [PS_W-1:0]  presc;
        logic [PS_W-1:0]  ps_mask;
        logic             hit;
        logic             wr_ctrl;
        logic             wr_preset;
        logic             wr_status;
        logic             enabled;
        logic             tick;
        logic             at_one;
        logic             term;
        logic [31:0]      rd_data;

        assign hit       = (ADD_I[5:4] == 2'(i));
        assign wr_ctrl   = WE_I && hit && (ADD_I[3:2] == SEL_CTRL);
        assign wr_preset = WE_I && hit && (ADD_I[3:2] == SEL_PRESET);
        assign wr_status = WE_I && hit && (ADD_I[3:2] == SEL_STATUS);

        // Reserved modes (MODE[1] set) freeze both prescaler and counter.
        assign enabled = ctrl[0] && !ctrl[2];
        assign ps_mask = PS_W'((16'd1 << ctrl[7:4]) - 16'd1);
        assign tick    = enabled && ((presc & ps_mask) == ps_mask);
        assign at_one  = (count == CNT_W'(1));
        assign term    = tick && at_one;

        // Register writes are applied after the tick so that they take priority.
        always_ff @(posedge CLK_I or posedge RST_I) begin
            if (RST_I) begin
                ctrl   <= '0;
                preset <= '0;
                count  <= '0;
                pend   <= 1'b0;
                presc  <= '0;
            end else begin
                if (enabled) begin
                    presc <= presc + PS_W'(1);
                end
                if (tick) begin
                    if (at_one) begin
                        if (ctrl[1]) begin
                            count <= preset;
                        end else begin
                            count   <= '0;
                            ctrl[0] <= 1'b0;
                        end
                    end else if (count != '0) begin
                        count <= count - CNT_W'(1);
                    end
                end
                if (wr_ctrl) begin
                    ctrl <= DAT_I[7:0];
                    if (DAT_I[0] && !ctrl[0]) begin
                        presc <= '0;
                    end
                end
                if (wr_preset) begin
                    preset <= DAT_I[CNT_W-1:0];
                    count  <= DAT_I[CNT_W-1:0];
                    presc  <= '0;
                end
                if (wr_status && DAT_I[0]) begin
                    pend <= 1'b0;
                end
                if (term) begin
                    pend <= 1'b1;
                end
            end
        end

        always_comb begin
            rd_data = '0;
            if (hit) begin
                case (ADD_I[3:2])
                    SEL_CTRL:   rd_data = {24'd0, ctrl};
                    SEL_PRESET: rd_data = 32'(preset);
                    SEL_COUNT:  rd_data = 32'(count);
                    SEL_STATUS: rd_data = {31'd0, pend};
                    default:    rd_data = '0;
                endcase
            end
        end

        assign rd_vec[i]  = rd_data;
        assign irq_vec[i] = pend && ctrl[3];
    end

    // Only the addressed channel contributes a non-zero word.
    always_comb begin
        DAT_O = '0;
        for (int i = 0; i < N_CH; i++) begin
            DAT_O = DAT_O | rd_vec[i];
        end
        if (RST_I) begin
            DAT_O = '0;
        end
    end

    assign IRQ = !RST_I && (|irq_vec);

endmodule

// File: tb/tb_multi_timer.sv
// Directed bench for multi_timer: default instance plus an 8-bit counter
// instance sharing the same register bus.
module tb_multi_timer;
    localparam logic [1:0] CTRL = 2'd0;
    localparam logic [1:0] PRE  = 2'd1;
    localparam logic [1:0] CNT  = 2'd2;
    localparam logic [1:0] STS  = 2'd3;

    logic        clk;
    logic        rst;
    logic [5:2]  add;
    logic        we;
    logic [31:0] dat;
    logic [31:0] dout;
    logic        irq;
    logic [31:0] dout8;
    logic        irq8;

    int total  = 0;
    int passed = 0;

    multi_timer #(.N_CH(2), .CNT_W(32)) u_dut (
        .CLK_I(clk), .RST_I(rst), .ADD_I(add), .WE_I(we),
        .DAT_I(dat), .DAT_O(dout), .IRQ(irq)
    );

    multi_timer #(.N_CH(2), .CNT_W(8)) u_dut8 (
        .CLK_I(clk), .RST_I(rst), .ADD_I(add), .WE_I(we),
        .DAT_I(dat), .DAT_O(dout8), .IRQ(irq8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a write for exactly one rising edge; caller is in the low phase.
    task automatic wr(input logic [1:0] c, input logic [1:0] s, input logic [31:0] d);
        add = {c, s};
        we  = 1'b1;
        dat = d;
        @(negedge clk);
        we  = 1'b0;
    endtask

    task automatic rd(input logic [1:0] c, input logic [1:0] s, output logic [31:0] v);
        add = {c, s};
        #1;
        v = dout;
    endtask

    task automatic test_reset;
        logic [31:0] v;
        rst = 1'b1;
        #1;
        total++; if (irq !== 1'b0) $display("FAIL rst_irq_during got %0b want 0", irq); else passed++;
        rd(2'd0, CTRL, v);
        total++; if (v !== 32'd0) $display("FAIL rst_ctrl_during got %0h want 0", v); else passed++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rd(2'd0, CNT, v);
        total++; if (v !== 32'd0) $display("FAIL rst_count got %0h want 0", v); else passed++;
        rd(2'd1, PRE, v);
        total++; if (v !== 32'd0) $display("FAIL rst_preset got %0h want 0", v); else passed++;
        rd(2'd1, STS, v);
        total++; if (v !== 32'd0) $display("FAIL rst_status got %0h want 0", v); else passed++;
    endtask

    task automatic test_oneshot;
        logic [31:0] v;
        @(negedge clk);
        wr(2'd0, PRE, 32'd3);
        wr(2'd0, CTRL, 32'h09);
        rd(2'd0, CNT, v);
        total++; if (v !== 32'd3) $display("FAIL os_cnt3 got %0h want 3", v); else passed++;
        @(negedge clk); rd(2'd0, CNT, v);
        total++; if (v !== 32'd2) $display("FAIL os_cnt2 got %0h want 2", v); else passed++;
        @(negedge clk); rd(2'd0, CNT, v);
        total++; if (v !== 32'd1) $display("FAIL os_cnt1 got %0h want 1", v); else passed++;
        total++; if (irq !== 1'b0) $display("FAIL os_irq_early got %0b want 0", irq); else passed++;
        @(negedge clk); rd(2'd0, CNT, v);
        total++; if (v !== 32'd0) $display("FAIL os_cnt0 got %0h want 0", v); else passed++;
        total++; if (irq !== 1'b1) $display("FAIL os_irq got %0b want 1", irq); else passed++;
        rd(2'd0, CTRL, v);
        total++; if (v !== 32'h08) $display("FAIL os_ctrl_selfclr got %0h want 8", v); else passed++;
        @(negedge clk); rd(2'd0, CNT, v);
        total++; if (v !== 32'd0) $display("FAIL os_cnt_hold got %0h want 0", v); else passed++;
        wr(2'd0, STS, 32'd1);
        rd(2'd0, STS, v);
        total++; if (v !== 32'd0) $display("FAIL os_w1c got %0h want 0", v); else passed++;
        total++; if (irq !== 1'b0) $display("FAIL os_irq_clr got %0b want 0", irq); else passed++;
    endtask

    task automatic test_autoreload;
        logic [31:0] v;
        @(negedge clk);
        wr(2'd1, PRE, 32'd2);
        wr(2'd1, CTRL, 32'h0B);
        rd(2'd1, CNT, v);
        total++; if (v !== 32'd2) $display("FAIL ar_cnt2a got %0h want 2", v); else passed++;
        @(negedge clk); rd(2'd1, CNT, v);
        total++; if (v !== 32'd1) $display("FAIL ar_cnt1a got %0h want 1", v); else passed++;
        @(negedge clk); rd(2'd1, CNT, v);
        total++; if (v !== 32'd2) $display("FAIL ar_reload got %0h want 2", v); else passed++;
        total++; if (irq !== 1'b1) $display("FAIL ar_irq1 got %0b want 1", irq); else passed++;
        wr(2'd1, STS, 32'd1);
        total++; if (irq !== 1'b0) $display("FAIL ar_w1c got %0b want 0", irq); else passed++;
        rd(2'd1, CNT, v);
        total++; if (v !== 32'd1) $display("FAIL ar_cnt1b got %0h want 1", v); else passed++;
        @(negedge clk);
        total++; if (irq !== 1'b1) $display("FAIL ar_irq2 got %0b want 1", irq); else passed++;
        wr(2'd1, CTRL, 32'h00);
        wr(2'd1, STS, 32'd1);
        total++; if (irq !== 1'b0) $display("FAIL ar_off got %0b want 0", irq); else passed++;
    endtask

    task automatic test_prescale;
        logic [31:0] v;
        @(negedge clk);
        wr(2'd0, PRE, 32'd4);
        wr(2'd0, CTRL, 32'h21);
        repeat (3) @(negedge clk);
        rd(2'd0, CNT, v);
        total++; if (v !== 32'd4) $display("FAIL ps_cnt_e3 got %0h want 4", v); else passed++;
        @(negedge clk); rd(2'd0, CNT, v);
        total++; if (v !== 32'd3) $display("FAIL ps_cnt_e4 got %0h want 3", v); else passed++;
        repeat (11) @(negedge clk);
        rd(2'd0, CNT, v);
        total++; if (v !== 32'd1) $display("FAIL ps_cnt_e15 got %0h want 1", v); else passed++;
        rd(2'd0, STS, v);
        total++; if (v !== 32'd0) $display("FAIL ps_pend_e15 got %0h want 0", v); else passed++;
        @(negedge clk); rd(2'd0, STS, v);
        total++; if (v !== 32'd1) $display("FAIL ps_pend_e16 got %0h want 1", v); else passed++;
        total++; if (irq !== 1'b0) $display("FAIL ps_irq_masked got %0b want 0", irq); else passed++;
        wr(2'd0, STS, 32'd1);
    endtask

    task automatic test_collisions;
        logic [31:0] v;
        @(negedge clk);
        wr(2'd1, PRE, 32'd1);
        wr(2'd1, CTRL, 32'h0B);
        wr(2'd1, STS, 32'd1);
        rd(2'd1, STS, v);
        total++; if (v !== 32'd1) $display("FAIL col_set_wins got %0h want 1", v); else passed++;
        total++; if (irq !== 1'b1) $display("FAIL col_irq got %0b want 1", irq); else passed++;
        wr(2'd1, PRE, 32'd5);
        rd(2'd1, CNT, v);
        total++; if (v !== 32'd5) $display("FAIL col_preset_wins got %0h want 5", v); else passed++;
        @(negedge clk); rd(2'd1, CNT, v);
        total++; if (v !== 32'd4) $display("FAIL col_after got %0h want 4", v); else passed++;
        wr(2'd1, CTRL, 32'h00);
        wr(2'd1, STS, 32'd1);
        rd(2'd1, CNT, v);
        total++; if (v !== 32'd3) $display("FAIL col_stop got %0h want 3", v); else passed++;
        total++; if (irq !== 1'b0) $display("FAIL col_irq_off got %0b want 0", irq); else passed++;
        // One-shot terminal event colliding with a CTRL write keeps the written EN.
        wr(2'd0, PRE, 32'd1);
        wr(2'd0, CTRL, 32'h01);
        wr(2'd0, CTRL, 32'h01);
        rd(2'd0, CTRL, v);
        total++; if (v !== 32'h01) $display("FAIL col_ctrl_wins got %0h want 1", v); else passed++;
        rd(2'd0, STS, v);
        total++; if (v !== 32'd1) $display("FAIL col_ctrl_pend got %0h want 1", v); else passed++;
        wr(2'd0, STS, 32'd1);
        @(negedge clk); rd(2'd0, STS, v);
        total++; if (v !== 32'd0) $display("FAIL zero_no_pend got %0h want 0", v); else passed++;
        rd(2'd0, CNT, v);
        total++; if (v !== 32'd0) $display("FAIL zero_hold got %0h want 0", v); else passed++;
        wr(2'd0, CTRL, 32'h00);
    endtask

    task automatic test_width_range;
        logic [31:0] v;
        @(negedge clk);
        wr(2'd0, PRE, 32'h1FF);
        add = {2'd0, PRE}; #1;
        total++; if (dout8 !== 32'hFF) $display("FAIL w8_preset got %0h want ff", dout8); else passed++;
        total++; if (dout !== 32'h1FF) $display("FAIL w32_preset got %0h want 1ff", dout); else passed++;
        add = {2'd0, CNT}; #1;
        total++; if (dout8 !== 32'hFF) $display("FAIL w8_count got %0h want ff", dout8); else passed++;
        wr(2'd3, PRE, 32'h55);
        wr(2'd3, CTRL, 32'h09);
        rd(2'd3, PRE, v);
        total++; if (v !== 32'd0) $display("FAIL ch3_preset got %0h want 0", v); else passed++;
        rd(2'd3, CTRL, v);
        total++; if (v !== 32'd0) $display("FAIL ch3_ctrl got %0h want 0", v); else passed++;
        rd(2'd1, PRE, v);
        total++; if (v !== 32'd5) $display("FAIL ch3_alias got %0h want 5", v); else passed++;
        wr(2'd1, CNT, 32'h77);
        rd(2'd1, CNT, v);
        total++; if (v !== 32'd3) $display("FAIL cnt_ro got %0h want 3", v); else passed++;
        rd(2'd0, CTRL, v);
        total++; if (v !== 32'd0) $display("FAIL ctrl_upper got %0h want 0", v); else passed++;
        wr(2'd0, CTRL, 32'hFFFF_FF00);
    endtask

    task automatic test_async_reset;
        logic [31:0] v;
        @(negedge clk);
        wr(2'd0, PRE, 32'd2);
        wr(2'd0, CTRL, 32'h0B);
        wr(2'd1, PRE, 32'd9);
        wr(2'd1, CTRL, 32'h01);
        total++; if (irq !== 1'b1) $display("FAIL ars_irq_pre got %0b want 1", irq); else passed++;
        #1 rst = 1'b1;
        #1;
        total++; if (irq !== 1'b0) $display("FAIL ars_irq got %0b want 0", irq); else passed++;
        total++; if (irq8 !== 1'b0) $display("FAIL ars_irq8 got %0b want 0", irq8); else passed++;
        rd(2'd0, CTRL, v);
        total++; if (v !== 32'd0) $display("FAIL ars_ctrl got %0h want 0", v); else passed++;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rd(2'd1, CNT, v);
        total++; if (v !== 32'd0) $display("FAIL ars_cnt1 got %0h want 0", v); else passed++;
        rd(2'd0, PRE, v);
        total++; if (v !== 32'd0) $display("FAIL ars_pre0 got %0h want 0", v); else passed++;
        rd(2'd1, CTRL, v);
        total++; if (v !== 32'd0) $display("FAIL ars_ctrl1 got %0h want 0", v); else passed++;
        total++; if (irq !== 1'b0) $display("FAIL ars_idle_irq got %0b want 0", irq); else passed++;
    endtask

    initial begin
        rst = 1'b1;
        we  = 1'b0;
        add = '0;
        dat = '0;
        test_reset;
        test_oneshot;
        test_autoreload;
        test_prescale;
        test_collisions;
        test_width_range;
        test_async_reset;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/multi_timer.md
MULTI_TIMER -- requirements
Module: multi_timer

Interface
REQ-001 Parameter N_CH, default 2, number of independent timer channels, legal range 1..4.
REQ-002 Parameter CNT_W, default 32, counter/preset width in bits, legal range 8..32.
REQ-003 CLK_I  input  1  single clock; all state updates on its rising edge.
REQ-004 RST_I  input  1  reset, asynchronous, active-high.
REQ-005 ADD_I  input  [5:2]  word address; [5:4] channel index c, [3:2] register select.
REQ-006 WE_I  input  1  write enable, one write per cycle when high.
REQ-007 DAT_I  input  32  write data.
REQ-008 DAT_O  output  32  read data, combinational from ADD_I and register state.
REQ-009 IRQ  output  1  combinational OR over channels of (PEND & IM).

Function
REQ-010 Per channel register map: sel 00 CTRL, 01 PRESET, 10 COUNT (read-only), 11 STATUS.
REQ-011 CTRL[0] EN, CTRL[2:1] MODE, CTRL[3] IM, CTRL[7:4] PS; write stores DAT_I[7:0], bits [31:8] read 0.
REQ-012 MODE 00 one-shot, 01 auto-reload, 10/11 reserved: counter and prescaler hold, no events.
REQ-013 PRESET write stores DAT_I[CNT_W-1:0], loads COUNT with the same value, and clears the channel prescaler in the same cycle.
REQ-014 Writes to COUNT are ignored; writes with c >= N_CH are ignored; reads with c >= N_CH return 0.
REQ-015 STATUS[0] PEND; writing 1 to DAT_I[0] clears PEND, writing 0 has no effect; STATUS[31:1] read 0.
REQ-016 COUNT and PRESET read zero-extended to 32 bits.
REQ-017 Prescaler per channel, 15-bit counter; tick asserted every 2^PS enabled cycles (PS=0: every cycle).
REQ-018 Prescaler advances only while EN=1 and MODE legal; a CTRL write that sets EN from 0 to 1 clears it.
REQ-019 On tick with COUNT > 1: COUNT <= COUNT - 1.
REQ-020 On tick with COUNT == 1, MODE 00: COUNT <= 0, PEND <= 1, EN <= 0 (hardware self-clear).
REQ-021 On tick with COUNT == 1, MODE 01: COUNT <= PRESET, PEND <= 1, EN unchanged.
REQ-022 On tick with COUNT == 0: no change, no PEND (covers PRESET == 0 in either mode).
REQ-023 Terminal event latency: PEND and IRQ visible the cycle after the edge on which COUNT left 1.
REQ-024 PRESET write and tick in the same cycle: write wins, tick discarded.
REQ-025 Terminal event and PEND W1C in the same cycle: set wins, PEND stays 1.
REQ-026 Terminal event (MODE 00) and CTRL write in the same cycle: CTRL write value wins, including EN.
REQ-027 Channels fully independent; simultaneous events on several channels all recorded.
REQ-028 IM gates IRQ only; PEND sets regardless of IM; clearing IM with PEND=1 deasserts IRQ immediately.

Reset
REQ-029 RST_I high clears CTRL, PRESET, COUNT, PEND and prescaler of every channel to 0 immediately, independent of CLK_I.
REQ-030 IRQ = 0 and DAT_O reads 0 for every address while RST_I is high.
REQ-031 Reset asserted mid-count abandons the count; after release all channels idle until reprogrammed.

Verification
REQ-032 Ch0 PRESET=3, CTRL=0x09 (EN, one-shot, IM, PS=0) -> COUNT 3,2,1,0 on successive edges; PEND=1, IRQ=1, CTRL[0]=0; COUNT holds 0.
REQ-033 Ch1 PRESET=2, CTRL=0x0B (auto-reload, IM) -> COUNT 2,1,2,1,...; PEND set each reload; W1C STATUS clears IRQ until next reload.
REQ-034 Ch0 PRESET=4, CTRL=0x21 (PS=2) -> COUNT decrements once per 4 cycles; PEND after 16 enabled cycles; IRQ stays 0 (IM=0).
REQ-035 Auto-reload PRESET=1: W1C STATUS on the same cycle as terminal event -> PEND remains 1; PRESET write colliding with tick -> COUNT equals written value.
REQ-036 CNT_W=8, write PRESET=0x1FF -> COUNT and PRESET read 0xFF; write to channel index 3 with N_CH=2 -> ignored, reads 0.
REQ-037 Assert RST_I asynchronously mid-count with IRQ high -> all registers 0 and IRQ 0 before the next CLK_I edge.
